// File: rtl/trashbin_bus_pkg.sv
// Shared types and default sizes for the TempRam arbiter slice.
package trashbin_bus_pkg;

    localparam int ADDR_W_DEF    = 14;
    localparam int DATA_W_DEF    = 32;
    localparam int MAX_BURST_DEF = 16;

    typedef enum logic {
        RR      = 1'b0,
        B_BURST = 1'b1
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

endpackage

// File: rtl/trashbin_rr_pick.sv
// Two-way round-robin picker: a tie goes to the port that was not granted last.
module trashbin_rr_pick (
    input  logic req_a,
    input  logic req_b,
    input  logic last_is_b,
    output logic gnt_a,
    output logic gnt_b
);

    // A wins when alone, or on a tie when B was served last.
    always_comb begin
        gnt_a = req_a & (~req_b | last_is_b);
        gnt_b = req_b & ~gnt_a;
    end

endmodule

// File: rtl/trashbin_mem_arbiter.sv
// Arbiter sharing the single-port TempRam between TrashbinCore (A) and DMA/debug (B).
// Round-robin by default; B may lock the RAM for up to MAX_BURST consecutive beats.
// Optional macro TRASHBIN_ARB_BOUNDS_EN: upper address bits checked, out-of-range
// accesses are neutralised and flagged on the sticky bound_err output.
module trashbin_mem_arbiter
    import trashbin_bus_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              CoreClock,
    input  logic              CoreResetN,
    input  logic              a_req,
    input  logic [31:0]       a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_we,
    output logic              a_gnt,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic [31:0]       b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_we,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              bound_err
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam bit BURST_OK = (MAX_BURST > 1);

    arb_state_t       state_q, state_d;
    port_id_t         last_q, last_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             a_rvalid_q, b_rvalid_q;
    logic             rr_gnt_a, rr_gnt_b;
    logic [31:0]      sel_addr;
    logic             sel_we;
    logic             any_gnt;
    logic             oob;
    logic [DATA_W-1:0] rdata_mux;

    trashbin_rr_pick u_pick (
        .req_a     (a_req),
        .req_b     (b_req),
        .last_is_b (last_q == PORT_B),
        .gnt_a     (rr_gnt_a),
        .gnt_b     (rr_gnt_b)
    );

    // Grant selection: round-robin normally; during a burst B owns every cycle it requests.
    always_comb begin
        a_gnt = rr_gnt_a;
        b_gnt = rr_gnt_b;
        if (state_q == B_BURST) begin
            b_gnt = b_req;
            a_gnt = a_req & ~b_req;
        end
    end

    // Route the granted port onto the RAM; A's address is shown when idle.
    always_comb begin
        any_gnt   = a_gnt | b_gnt;
        sel_addr  = b_gnt ? b_addr  : a_addr;
        sel_we    = b_gnt ? b_we    : a_we;
        ram_wdata = b_gnt ? b_wdata : a_wdata;
        ram_addr  = sel_addr[ADDR_W-1:0];
        ram_we    = any_gnt & sel_we & ~oob;
    end

    // FSM next state, last-served port and burst beat count.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            RR: begin
                if (a_gnt) begin
                    last_d = PORT_A;
                end else if (b_gnt) begin
                    last_d = PORT_B;
                    if (b_lock && BURST_OK) begin
                        state_d    = B_BURST;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
            end
            B_BURST: begin
                // An A grant in a B gap is not a beat and leaves the burst running.
                if (b_gnt) begin
                    if (!b_lock || beat_cnt_q == LAST_BEAT) begin
                        state_d    = RR;
                        last_d     = PORT_B;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = RR;
                beat_cnt_d = '0;
            end
        endcase
    end

    // State registers and one-cycle read-valid pipeline; reset drops any pending rvalid.
    always_ff @(posedge CoreClock) begin
        if (!CoreResetN) begin
            state_q    <= RR;
            last_q     <= PORT_B;
            beat_cnt_q <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            a_rvalid_q <= a_gnt & ~a_we;
            b_rvalid_q <= b_gnt & ~b_we;
        end
    end

`ifdef TRASHBIN_ARB_BOUNDS_EN
    logic bound_err_q;
    logic oob_rd_q;

    assign oob = any_gnt & (sel_addr[31:ADDR_W] != '0);

    // Sticky range error, plus a marker so an out-of-range read returns zero.
    always_ff @(posedge CoreClock) begin
        if (!CoreResetN) begin
            bound_err_q <= 1'b0;
            oob_rd_q    <= 1'b0;
        end else begin
            if (oob) begin
                bound_err_q <= 1'b1;
            end
            oob_rd_q <= oob & ~sel_we;
        end
    end

    assign bound_err = bound_err_q;
    assign rdata_mux = oob_rd_q ? '0 : ram_rdata;
`else
    // Upper address bits alias onto the RAM; they are deliberately ignored.
    logic addr_hi_unused;
    assign addr_hi_unused = ^sel_addr[31:ADDR_W];
    assign oob       = 1'b0;
    assign bound_err = 1'b0;
    assign rdata_mux = ram_rdata;
`endif

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = rdata_mux;
    assign b_rdata  = rdata_mux;

endmodule

// File: tb/tb_trashbin_mem_arbiter.sv
// Self-checking bench for trashbin_mem_arbiter with a behavioural arbitration model.
module tb_trashbin_mem_arbiter;

    localparam int AW        = 14;
    localparam int DW        = 32;
    localparam int MAX_BURST = 16;
    localparam int DEPTH     = 1 << AW;

    logic          CoreClock, CoreResetN;
    logic          a_req, a_we, a_gnt, a_rvalid;
    logic [31:0]   a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_lock, b_gnt, b_rvalid;
    logic [31:0]   b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          ram_we, bound_err;

    int n_checks = 0;
    int n_fail   = 0;

    // TempRam stand-in and the model's own view of memory
    logic [DW-1:0] ram   [DEPTH];
    logic [DW-1:0] m_mem [DEPTH];

    // model state
    int            m_last;   // 0 = A served last, 1 = B
    bit            m_burst;
    int            m_beats;
    bit            m_ga, m_gb, m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            m_rva, m_rvb, m_bound;
    logic [DW-1:0] m_rd_a, m_rd_b;

    trashbin_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAX_BURST)) dut (
        .CoreClock (CoreClock), .CoreResetN (CoreResetN),
        .a_req (a_req), .a_addr (a_addr), .a_wdata (a_wdata), .a_we (a_we),
        .a_gnt (a_gnt), .a_rdata (a_rdata), .a_rvalid (a_rvalid),
        .b_req (b_req), .b_addr (b_addr), .b_wdata (b_wdata), .b_we (b_we),
        .b_gnt (b_gnt), .b_rdata (b_rdata), .b_rvalid (b_rvalid), .b_lock (b_lock),
        .ram_addr (ram_addr), .ram_wdata (ram_wdata), .ram_we (ram_we),
        .ram_rdata (ram_rdata), .bound_err (bound_err)
    );

    initial begin
        CoreClock = 1'b0;
        forever #5 CoreClock = ~CoreClock;
    end

    always @(posedge CoreClock) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic bit in_range(input logic [31:0] addr);
`ifdef TRASHBIN_ARB_BOUNDS_EN
        return addr[31:AW] == '0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom_range(0, 63);
        if ($urandom_range(0, 7) == 0) r = r | 32'h0000_4000;
        return r;
    endfunction

    // Expected grants and RAM write for the inputs currently driven.
    task automatic settle();
        #1;
        if (m_burst) begin
            m_gb = b_req;
            m_ga = a_req && !b_req;
        end else if (a_req && b_req) begin
            m_ga = (m_last == 1);
            m_gb = !m_ga;
        end else begin
            m_ga = a_req;
            m_gb = b_req;
        end
        m_we    = (m_ga && a_we && in_range(a_addr)) || (m_gb && b_we && in_range(b_addr));
        m_waddr = m_gb ? b_addr[AW-1:0] : a_addr[AW-1:0];
        m_wdata = m_gb ? b_wdata : a_wdata;
    endtask

    // Advance the model across one rising edge, then return at the falling edge.
    task automatic clock();
        logic [31:0] ad;
        @(posedge CoreClock);
        if (!CoreResetN) begin
            m_rva = 0; m_rvb = 0; m_last = 1; m_burst = 0; m_beats = 0; m_bound = 0;
        end else begin
            m_rva = m_ga && !a_we;
            m_rvb = m_gb && !b_we;
            if (m_ga || m_gb) begin
                ad = m_gb ? b_addr : a_addr;
                if (!in_range(ad)) begin
                    m_bound = 1;
                    if (m_ga) m_rd_a = '0; else m_rd_b = '0;
                end else if (m_ga) begin
                    if (a_we) m_mem[ad[AW-1:0]] = a_wdata; else m_rd_a = m_mem[ad[AW-1:0]];
                end else begin
                    if (b_we) m_mem[ad[AW-1:0]] = b_wdata; else m_rd_b = m_mem[ad[AW-1:0]];
                end
            end
            if (!m_burst) begin
                if (m_ga) m_last = 0;
                if (m_gb) begin
                    m_last = 1;
                    if (b_lock && MAX_BURST > 1) begin m_burst = 1; m_beats = 1; end
                end
            end else if (m_gb) begin
                m_beats++;
                if (!b_lock || m_beats >= MAX_BURST) begin m_burst = 0; m_beats = 0; m_last = 1; end
            end
        end
        @(negedge CoreClock);
    endtask

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_addr = 32'h0; a_wdata = '0;
        b_req = 0; b_we = 0; b_lock = 0; b_addr = 32'h0; b_wdata = '0;
    endtask

    task automatic do_reset();
        CoreResetN = 1'b0;
        idle_inputs();
        settle();
        clock();
        clock();
        CoreResetN = 1'b1;
    endtask

    task automatic test_reset();
        CoreResetN = 1'b0;
        idle_inputs();
        a_addr = 32'h0000_0123;
        settle();
        clock();
        settle();
        n_checks++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_gnt: got a=%b b=%b we=%b required 0 0 0", a_gnt, b_gnt, ram_we);
        end
        n_checks++;
        if (ram_addr !== 14'h0123) begin
            n_fail++;
            $display("FAIL reset_idle_addr: got %h required 0123", ram_addr);
        end
        clock();
        n_checks++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || bound_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got arv=%b brv=%b berr=%b required 0 0 0", a_rvalid, b_rvalid, bound_err);
        end
        CoreResetN = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        idle_inputs();
        a_req = 1; a_addr = 32'h10;
        settle();
        n_checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || ram_addr !== 14'h10) begin
            n_fail++;
            $display("FAIL single_read_gnt: got a=%b b=%b addr=%h required 1 0 0010", a_gnt, b_gnt, ram_addr);
        end
        clock();
        a_req = 0;
        settle();
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== m_mem[16]) begin
            n_fail++;
            $display("FAIL single_read_data: got rv=%b d=%h required 1 %h", a_rvalid, a_rdata, m_mem[16]);
        end
        clock();
        n_checks++;
        if (a_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_rv_drop: got %b required 0", a_rvalid);
        end
        $display("test_single_read done");
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_req = 1; a_we = $urandom_range(0, 1); a_addr = $urandom_range(0, 63); a_wdata = $urandom;
            b_req = 1; b_we = $urandom_range(0, 1); b_addr = $urandom_range(0, 63); b_wdata = $urandom;
            settle();
            n_checks++;
            if (a_gnt !== (i % 2 == 0) || b_gnt !== (i % 2 == 1)) begin
                n_fail++;
                $display("FAIL rr_order cyc %0d: got a=%b b=%b required a=%b b=%b", i, a_gnt, b_gnt, i % 2 == 0, i % 2 == 1);
            end
            n_checks++;
            if (ram_we !== m_we || (m_we && (ram_addr !== m_waddr || ram_wdata !== m_wdata))) begin
                n_fail++;
                $display("FAIL rr_ram cyc %0d: got we=%b a=%h d=%h required we=%b a=%h d=%h", i, ram_we, ram_addr, ram_wdata, m_we, m_waddr, m_wdata);
            end
            clock();
            n_checks++;
            if (a_rvalid !== m_rva || b_rvalid !== m_rvb || (m_rva && a_rdata !== m_rd_a) || (m_rvb && b_rdata !== m_rd_b)) begin
                n_fail++;
                $display("FAIL rr_read cyc %0d: got rv=%b%b d=%h required rv=%b%b", i, a_rvalid, b_rvalid, a_rdata, m_rva, m_rvb);
            end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_burst();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            a_req = 1; a_we = 0; a_addr = $urandom_range(0, 63);
            b_req = 1; b_we = 0; b_lock = 1; b_addr = $urandom_range(0, 63);
            settle();
            n_checks++;
            if (a_gnt !== (i == 0 || i == 17) || b_gnt !== !(i == 0 || i == 17) || a_gnt !== m_ga) begin
                n_fail++;
                $display("FAIL burst_gnt cyc %0d: got a=%b b=%b required a=%b", i, a_gnt, b_gnt, i == 0 || i == 17);
            end
            clock();
            n_checks++;
            if (a_rvalid !== m_rva || b_rvalid !== m_rvb || (m_rva && a_rdata !== m_rd_a) || (m_rvb && b_rdata !== m_rd_b)) begin
                n_fail++;
                $display("FAIL burst_read cyc %0d: got rv=%b%b d=%h required rv=%b%b", i, a_rvalid, b_rvalid, b_rdata, m_rva, m_rvb);
            end
        end
        $display("test_burst done");
    endtask

    task automatic test_burst_gap();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            a_req = (i >= 1); a_we = 0; a_addr = $urandom_range(0, 63);
            b_req = (i != 4); b_we = $urandom_range(0, 1); b_lock = 1;
            b_addr = $urandom_range(0, 63); b_wdata = $urandom;
            settle();
            n_checks++;
            if (a_gnt !== (i == 4 || i == 17) || b_gnt !== !(i == 4 || i == 17)) begin
                n_fail++;
                $display("FAIL gap_gnt cyc %0d: got a=%b b=%b required a=%b", i, a_gnt, b_gnt, i == 4 || i == 17);
            end
            n_checks++;
            if (ram_we !== m_we || (m_we && (ram_addr !== m_waddr || ram_wdata !== m_wdata))) begin
                n_fail++;
                $display("FAIL gap_ram cyc %0d: got we=%b a=%h required we=%b a=%h", i, ram_we, ram_addr, m_we, m_waddr);
            end
            clock();
        end
        $display("test_burst_gap done");
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        b_req = 1; b_lock = 1; b_we = 0; b_addr = 32'h5;
        settle();
        clock();
        b_addr = 32'h6;
        CoreResetN = 1'b0;
        settle();
        n_checks++;
        if (b_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_gnt: got b=%b required 1", b_gnt);
        end
        clock();
        CoreResetN = 1'b1;
        a_req = 1; a_we = 0; a_addr = 32'h7;
        settle();
        n_checks++;
        if (b_rvalid !== 1'b0 || a_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_rvalid: got a=%b b=%b required 0 0", a_rvalid, b_rvalid);
        end
        n_checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_tie: got a=%b b=%b required 1 0", a_gnt, b_gnt);
        end
        clock();
        $display("test_reset_mid_burst done");
    endtask

    task automatic test_bounds();
        do_reset();
        a_req = 1; a_we = 1; a_addr = 32'h0000_4010; a_wdata = 32'hCAFE_F00D;
        settle();
`ifdef TRASHBIN_ARB_BOUNDS_EN
        n_checks++;
        if (a_gnt !== 1'b1 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL bounds_wr: got gnt=%b we=%b required 1 0", a_gnt, ram_we);
        end
        clock();
        a_we = 0;
        settle();
        clock();
        a_req = 0;
        settle();
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h0 || bound_err !== 1'b1) begin
            n_fail++;
            $display("FAIL bounds_rd: got rv=%b d=%h err=%b required 1 0 1", a_rvalid, a_rdata, bound_err);
        end
        a_req = 1; a_addr = 32'h3; settle(); clock(); a_req = 0; settle(); clock();
        n_checks++;
        if (bound_err !== 1'b1) begin
            n_fail++;
            $display("FAIL bounds_sticky: got %b required 1", bound_err);
        end
`else
        n_checks++;
        if (a_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 14'h0010) begin
            n_fail++;
            $display("FAIL alias_wr: got gnt=%b we=%b a=%h required 1 1 0010", a_gnt, ram_we, ram_addr);
        end
        clock();
        a_we = 0; a_addr = 32'h10;
        settle();
        clock();
        a_req = 0;
        settle();
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'hCAFE_F00D || bound_err !== 1'b0) begin
            n_fail++;
            $display("FAIL alias_rd: got rv=%b d=%h err=%b required 1 cafef00d 0", a_rvalid, a_rdata, bound_err);
        end
        clock();
`endif
        $display("test_bounds done");
    endtask

    task automatic test_random();
        bit pa, pb;
        do_reset();
        pa = 1; pb = 1;
        for (int i = 0; i < 400; i++) begin
            if (pa || !a_req) begin
                a_req = ($urandom_range(0, 3) != 0); a_we = $urandom_range(0, 1);
                a_addr = rand_addr(); a_wdata = $urandom;
            end else if ($urandom_range(0, 9) == 0) a_req = 0;
            if (pb || !b_req) begin
                b_req = ($urandom_range(0, 2) != 0); b_we = $urandom_range(0, 1);
                b_addr = rand_addr(); b_wdata = $urandom;
            end else if ($urandom_range(0, 9) == 0) b_req = 0;
            b_lock = ($urandom_range(0, 3) != 0);
            settle();
            n_checks++;
            if (a_gnt !== m_ga || b_gnt !== m_gb) begin
                n_fail++;
                $display("FAIL rand_gnt cyc %0d: got a=%b b=%b required a=%b b=%b", i, a_gnt, b_gnt, m_ga, m_gb);
            end
            n_checks++;
            if (ram_we !== m_we || (m_we && (ram_addr !== m_waddr || ram_wdata !== m_wdata))) begin
                n_fail++;
                $display("FAIL rand_ram cyc %0d: got we=%b a=%h d=%h required we=%b a=%h d=%h", i, ram_we, ram_addr, ram_wdata, m_we, m_waddr, m_wdata);
            end
            pa = m_ga; pb = m_gb;
            clock();
            n_checks++;
            if (a_rvalid !== m_rva || b_rvalid !== m_rvb || (m_rva && a_rdata !== m_rd_a) || (m_rvb && b_rdata !== m_rd_b)) begin
                n_fail++;
                $display("FAIL rand_read cyc %0d: got rv=%b%b a=%h b=%h required rv=%b%b a=%h b=%h", i, a_rvalid, b_rvalid, a_rdata, b_rdata, m_rva, m_rvb, m_rd_a, m_rd_b);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]   = 32'h9E37_79B9 * i + 32'h1234_5678;
            m_mem[i] = 32'h9E37_79B9 * i + 32'h1234_5678;
        end
        m_last = 1; m_burst = 0; m_beats = 0; m_rva = 0; m_rvb = 0; m_bound = 0;
        m_rd_a = '0; m_rd_b = '0;
        CoreResetN = 1'b0;
        idle_inputs();
        @(negedge CoreClock);
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst();
        test_burst_gap();
        test_reset_mid_burst();
        test_bounds();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
